io_stage: RTL and testbench
===========================

IO_STAGE -- requirements
Module: io_stage

Interface
REQ-001 SHALL have ports `clock` and `reset`: reset is synchronous and active-high; clock is `clock`.
REQ-002 SHALL have ports (name  direction  width  meaning):
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous active-high reset.
- `wb_allow_in`  in  1  WB stage can accept.
- `io_allow_in`  out  1  this stage can accept from EX.
- `ex_to_io_bus`  in  ex_stage_params::EXToIOData  fields: valid, program_count, alu_result, source_register_data, destination_register, register_write, memory_address_final[1:0], is_load_left/right/half_word/byte, memory_io_unsigned, result_is_from_memory, multiply_valid, multiply_result[63:0], divide_valid, divide_result_valid, divide_result, divide_remain, result_high, result_low, high_low_write.
- `data_ram_read_data`  in  32  sync-SRAM read data for the address EX issued last cycle.
- `io_to_wb_valid`  out  1  bundle to WB valid.
- `io_to_wb_program_count`  out  32  PC of instruction in IO.
- `io_to_wb_destination_register`  out  5  GPR index.
- `io_to_wb_register_write`  out  1  GPR write enable.
- `io_to_wb_result`  out  32  final GPR write data.
- `io_to_id_back_pass_valid`  out  1  IO holds a GPR writer.
- `io_to_id_back_pass_data_valid`  out  1  write data is final and forwardable.
- `io_to_id_back_pass_register`  out  5  destination GPR.
- `io_to_id_back_pass_data`  out  32  forward data.
REQ-003 SHALL own the architectural `hi` and `lo` registers (32 bits each); they are internal, not ports.

Function
REQ-004 SHALL hold a single-entry pipeline register: `io_valid` plus a latched copy of `ex_to_io_bus`.
REQ-005 SHALL latch the bus when `ex_to_io_bus.valid && io_allow_in`; `io_valid` SHALL load `ex_to_io_bus.valid` whenever `io_allow_in`.
REQ-006 SHALL compute `io_ready_go = !(divide_valid && !divide_result_valid)`, using the live divider signals from the bus; all other instructions take 1 cycle.
REQ-007 SHALL drive `io_allow_in = !io_valid || (io_ready_go && wb_allow_in)` and `io_to_wb_valid = io_valid && io_ready_go`.
REQ-008 SHALL extract load data from `data_ram_read_data` at byte offset a = `memory_address_final`:
- byte: `rd[8a+7:8a]`.
- half-word: `rd[16*a[1]+15:16*a[1]]`.
- Both SHALL zero-extend if `memory_io_unsigned`, otherwise sign-extend.
- Plain word: `rd`.
REQ-009 SHALL merge LWL with old rt = `source_register_data` (r):
- a=0: `{rd[7:0], r[23:0]}`
- a=1: `{rd[15:0], r[15:0]}`
- a=2: `{rd[23:0], r[7:0]}`
- a=3: `rd`
REQ-010 SHALL merge LWR as:
- a=0: `rd`
- a=1: `{r[31:24], rd[31:8]}`
- a=2: `{r[31:16], rd[31:16]}`
- a=3: `{r[31:8], rd[31:24]}`
REQ-011 SHALL select the result with priority: `result_is_from_memory` → load data; else `result_high` && !`high_low_write` → `hi`; else `result_low` && !`high_low_write` → `lo`; else `alu_result`.
REQ-012 SHALL update HI/LO only on handoff (`io_valid && io_ready_go && wb_allow_in`) and only when `high_low_write`:
- multiply_valid: `hi` ← result[63:32], `lo` ← result[31:0].
- divide_valid: `lo` ← divide_result, `hi` ← divide_remain.
- otherwise (MTHI/MTLO): `hi` ← source_register_data if result_high; `lo` ← source_register_data if result_low.
REQ-013 SHALL make an MFHI/MFLO in IO read the `hi`/`lo` register value, which includes all updates committed by older instructions.
REQ-014 SHALL drive `io_to_id_back_pass_valid = io_valid && register_write`, `io_to_id_back_pass_data_valid = io_to_id_back_pass_valid && io_ready_go`, register = destination_register, data = selected result.
REQ-015 SHALL, while stalled (valid, !ready_go or !wb_allow_in), hold the latched bundle and HI/LO unchanged, keep `io_allow_in` = 0, and keep outputs stable.
REQ-016 SHALL, when wb_allow_in=1 and a new EX instruction arrives on the same edge as handoff, commit the old instruction's HI/LO and latch the new one.

Reset
REQ-017 SHALL, on reset, clear `io_valid`, `hi` and `lo` to 0; `io_to_wb_valid`, both back-pass valids, and `io_allow_in`-blocking SHALL deassert the cycle after reset.
REQ-018 SHALL have reset dominate any concurrent latch or HI/LO update; a divide stalled in IO SHALL be discarded.

Verification
REQ-019 SHALL verify LB: rd=0x0000_80FF, a=1, signed → result 0xFFFF_FF80; with unsigned → 0x0000_0080.
REQ-020 SHALL verify LWL/LWR: rd=0x1122_3344, r=0xAABB_CCDD, a=1 → LWL result 0x3344_CCDD and LWR result 0xAA11_2233.
REQ-021 SHALL verify MULT then MFHI: multiply_result=0x0000_0001_FFFF_FFFE → next MFHI result 0x0000_0001; MFLO result 0xFFFF_FFFE.
REQ-022 SHALL verify a DIV stall: divide_result_valid held 0 for 5 cycles → io_to_wb_valid=0, io_allow_in=0, back-pass data_valid=0. Then 1 → handoff in the same cycle, lo=quotient, hi=remainder.
REQ-023 SHALL verify WB backpressure: wb_allow_in=0 for 3 cycles with a valid ALU op → outputs held stable, no HI/LO change, io_allow_in=0.
REQ-024 SHALL verify reset while a DIV is stalled: assert reset → next cycle io_valid=0, hi=lo=0.

Source files
------------

// File: rtl/io_stage.sv
// IO pipeline stage: aligns load data from the data SRAM, owns the HI/LO pair,
// and hands the final GPR write data to WB and the ID forwarding network.
package ex_stage_params;
    typedef struct packed {
        logic        valid;
        logic [31:0] program_count;
        logic [31:0] alu_result;
        logic [31:0] source_register_data;
        logic [4:0]  destination_register;
        logic        register_write;
        logic [1:0]  memory_address_final;
        logic        is_load_left;
        logic        is_load_right;
        logic        is_load_half_word;
        logic        is_load_byte;
        logic        memory_io_unsigned;
        logic        result_is_from_memory;
        logic        multiply_valid;
        logic [63:0] multiply_result;
        logic        divide_valid;
        logic        divide_result_valid;
        logic [31:0] divide_result;
        logic [31:0] divide_remain;
        logic        result_high;
        logic        result_low;
        logic        high_low_write;
    } EXToIOData;
endpackage

module io_stage (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wb_allow_in,
    output logic                        io_allow_in,
    input  ex_stage_params::EXToIOData  ex_to_io_bus,
    input  logic [31:0]                 data_ram_read_data,
    output logic                        io_to_wb_valid,
    output logic [31:0]                 io_to_wb_program_count,
    output logic [4:0]                  io_to_wb_destination_register,
    output logic                        io_to_wb_register_write,
    output logic [31:0]                 io_to_wb_result,
    output logic                        io_to_id_back_pass_valid,
    output logic                        io_to_id_back_pass_data_valid,
    output logic [4:0]                  io_to_id_back_pass_register,
    output logic [31:0]                 io_to_id_back_pass_data
);

    logic        io_valid;
    logic        io_ready_go;
    logic        handoff;

    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [31:0] src_q;
    logic [4:0]  dest_q;
    logic        reg_write_q;
    logic [1:0]  addr_q;
    logic        load_left_q;
    logic        load_right_q;
    logic        load_half_q;
    logic        load_byte_q;
    logic        unsigned_q;
    logic        from_mem_q;
    logic        mult_q;
    logic [63:0] mult_result_q;
    logic        div_q;
    logic        result_high_q;
    logic        result_low_q;
    logic        hl_write_q;

    logic [31:0] hi;
    logic [31:0] lo;

    logic [7:0]  byte_data;
    logic [15:0] half_data;
    logic [31:0] lwl_data;
    logic [31:0] lwr_data;
    logic [31:0] load_data;
    logic [31:0] result;

    // The divider keeps running in EX after the DIV has moved here, so its
    // handshake and results are taken from the live bus, not the latched copy.
    assign io_ready_go = !(ex_to_io_bus.divide_valid && !ex_to_io_bus.divide_result_valid);
    assign io_allow_in = !io_valid || (io_ready_go && wb_allow_in);
    assign handoff     = io_valid && io_ready_go && wb_allow_in;

    always_ff @(posedge clock) begin
        if (reset) begin
            io_valid <= 1'b0;
        end else if (io_allow_in) begin
            io_valid <= ex_to_io_bus.valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= '0;
            alu_q         <= '0;
            src_q         <= '0;
            dest_q        <= '0;
            reg_write_q   <= 1'b0;
            addr_q        <= '0;
            load_left_q   <= 1'b0;
            load_right_q  <= 1'b0;
            load_half_q   <= 1'b0;
            load_byte_q   <= 1'b0;
            unsigned_q    <= 1'b0;
            from_mem_q    <= 1'b0;
            mult_q        <= 1'b0;
            mult_result_q <= '0;
            div_q         <= 1'b0;
            result_high_q <= 1'b0;
            result_low_q  <= 1'b0;
            hl_write_q    <= 1'b0;
        end else if (ex_to_io_bus.valid && io_allow_in) begin
            pc_q          <= ex_to_io_bus.program_count;
            alu_q         <= ex_to_io_bus.alu_result;
            src_q         <= ex_to_io_bus.source_register_data;
            dest_q        <= ex_to_io_bus.destination_register;
            reg_write_q   <= ex_to_io_bus.register_write;
            addr_q        <= ex_to_io_bus.memory_address_final;
            load_left_q   <= ex_to_io_bus.is_load_left;
            load_right_q  <= ex_to_io_bus.is_load_right;
            load_half_q   <= ex_to_io_bus.is_load_half_word;
            load_byte_q   <= ex_to_io_bus.is_load_byte;
            unsigned_q    <= ex_to_io_bus.memory_io_unsigned;
            from_mem_q    <= ex_to_io_bus.result_is_from_memory;
            mult_q        <= ex_to_io_bus.multiply_valid;
            mult_result_q <= ex_to_io_bus.multiply_result;
            div_q         <= ex_to_io_bus.divide_valid;
            result_high_q <= ex_to_io_bus.result_high;
            result_low_q  <= ex_to_io_bus.result_low;
            hl_write_q    <= ex_to_io_bus.high_low_write;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (handoff && hl_write_q) begin
            if (mult_q) begin
                hi <= mult_result_q[63:32];
                lo <= mult_result_q[31:0];
            end else if (div_q) begin
                hi <= ex_to_io_bus.divide_remain;
                lo <= ex_to_io_bus.divide_result;
            end else begin
                if (result_high_q) hi <= src_q;
                if (result_low_q)  lo <= src_q;
            end
        end
    end

    // Load alignment, LWL/LWR merge with the old rt value, then result select.
    always_comb begin
        byte_data = 8'h00;
        lwl_data  = data_ram_read_data;
        lwr_data  = data_ram_read_data;
        case (addr_q)
            2'd0: begin
                byte_data = data_ram_read_data[7:0];
                lwl_data  = {data_ram_read_data[7:0], src_q[23:0]};
                lwr_data  = data_ram_read_data;
            end
            2'd1: begin
                byte_data = data_ram_read_data[15:8];
                lwl_data  = {data_ram_read_data[15:0], src_q[15:0]};
                lwr_data  = {src_q[31:24], data_ram_read_data[31:8]};
            end
            2'd2: begin
                byte_data = data_ram_read_data[23:16];
                lwl_data  = {data_ram_read_data[23:0], src_q[7:0]};
                lwr_data  = {src_q[31:16], data_ram_read_data[31:16]};
            end
            2'd3: begin
                byte_data = data_ram_read_data[31:24];
                lwl_data  = data_ram_read_data;
                lwr_data  = {src_q[31:8], data_ram_read_data[31:24]};
            end
            default: ;
        endcase
        half_data = addr_q[1] ? data_ram_read_data[31:16] : data_ram_read_data[15:0];

        if (load_left_q) begin
            load_data = lwl_data;
        end else if (load_right_q) begin
            load_data = lwr_data;
        end else if (load_byte_q) begin
            load_data = unsigned_q ? {24'h0, byte_data} : {{24{byte_data[7]}}, byte_data};
        end else if (load_half_q) begin
            load_data = unsigned_q ? {16'h0, half_data} : {{16{half_data[15]}}, half_data};
        end else begin
            load_data = data_ram_read_data;
        end

        if (from_mem_q) begin
            result = load_data;
        end else if (result_high_q && !hl_write_q) begin
            result = hi;
        end else if (result_low_q && !hl_write_q) begin
            result = lo;
        end else begin
            result = alu_q;
        end
    end

    assign io_to_wb_valid                = io_valid && io_ready_go;
    assign io_to_wb_program_count        = pc_q;
    assign io_to_wb_destination_register = dest_q;
    assign io_to_wb_register_write       = reg_write_q;
    assign io_to_wb_result               = result;

    assign io_to_id_back_pass_valid      = io_valid && reg_write_q;
    assign io_to_id_back_pass_data_valid = io_to_id_back_pass_valid && io_ready_go;
    assign io_to_id_back_pass_register   = dest_q;
    assign io_to_id_back_pass_data       = result;

endmodule

// File: tb/tb_io_stage.sv
// Self-checking bench for io_stage: a behavioural model checked every cycle,
// plus directed loads, HI/LO traffic, divide stalls, backpressure and reset.
module tb_io_stage;
    import ex_stage_params::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wb_allow_in = 1'b1;
    EXToIOData   bus = '0;
    logic [31:0] rd = '0;

    logic        io_allow_in;
    logic        io_to_wb_valid;
    logic [31:0] io_to_wb_program_count;
    logic [4:0]  io_to_wb_destination_register;
    logic        io_to_wb_register_write;
    logic [31:0] io_to_wb_result;
    logic        io_to_id_back_pass_valid;
    logic        io_to_id_back_pass_data_valid;
    logic [4:0]  io_to_id_back_pass_register;
    logic [31:0] io_to_id_back_pass_data;

    int checkCount = 0;
    int failCount  = 0;

    io_stage dut (
        .clock                         (clock),
        .reset                         (reset),
        .wb_allow_in                   (wb_allow_in),
        .io_allow_in                   (io_allow_in),
        .ex_to_io_bus                  (bus),
        .data_ram_read_data            (rd),
        .io_to_wb_valid                (io_to_wb_valid),
        .io_to_wb_program_count        (io_to_wb_program_count),
        .io_to_wb_destination_register (io_to_wb_destination_register),
        .io_to_wb_register_write       (io_to_wb_register_write),
        .io_to_wb_result               (io_to_wb_result),
        .io_to_id_back_pass_valid      (io_to_id_back_pass_valid),
        .io_to_id_back_pass_data_valid (io_to_id_back_pass_data_valid),
        .io_to_id_back_pass_register   (io_to_id_back_pass_register),
        .io_to_id_back_pass_data       (io_to_id_back_pass_data)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: the instruction held in IO plus architectural HI/LO.
    logic        m_valid = 1'b0;
    EXToIOData   m_ins = '0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    function automatic logic [31:0] expResult(input EXToIOData i, input logic [31:0] d,
                                              input logic [31:0] h, input logic [31:0] l);
        int          a;
        int          sh;
        logic [63:0] mask;
        logic [31:0] v;
        a = int'(i.memory_address_final);
        if (i.result_is_from_memory) begin
            if (i.is_load_left) begin
                sh   = 8 * (3 - a);
                mask = (64'd1 << sh) - 64'd1;
                v    = (d << sh) | (i.source_register_data & mask[31:0]);
            end else if (i.is_load_right) begin
                sh = 8 * a;
                v  = (d >> sh) | (i.source_register_data & ~(32'hFFFF_FFFF >> sh));
            end else if (i.is_load_byte) begin
                v = (d >> (8 * a)) & 32'h0000_00FF;
                if (!i.memory_io_unsigned && v[7]) v = v | 32'hFFFF_FF00;
            end else if (i.is_load_half_word) begin
                v = (d >> (16 * (a / 2))) & 32'h0000_FFFF;
                if (!i.memory_io_unsigned && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = d;
            end
        end else if (i.result_high && !i.high_low_write) begin
            v = h;
        end else if (i.result_low && !i.high_low_write) begin
            v = l;
        end else begin
            v = i.alu_result;
        end
        return v;
    endfunction

    always @(posedge clock) begin : model
        logic ready;
        ready = !(bus.divide_valid && !bus.divide_result_valid);
        if (reset) begin
            m_valid = 1'b0;
            m_hi    = '0;
            m_lo    = '0;
        end else begin
            if (m_valid && ready && wb_allow_in && m_ins.high_low_write) begin
                if (m_ins.multiply_valid) begin
                    {m_hi, m_lo} = m_ins.multiply_result;
                end else if (m_ins.divide_valid) begin
                    m_lo = bus.divide_result;
                    m_hi = bus.divide_remain;
                end else begin
                    if (m_ins.result_high) m_hi = m_ins.source_register_data;
                    if (m_ins.result_low)  m_lo = m_ins.source_register_data;
                end
            end
            if (!m_valid || (ready && wb_allow_in)) begin
                m_valid = bus.valid;
                if (bus.valid) m_ins = bus;
            end
        end
    end

    always @(negedge clock) begin : compare
        logic ready;
        logic pass;
        if (!reset) begin
            ready = !(bus.divide_valid && !bus.divide_result_valid);
            pass  = m_valid && m_ins.register_write;
            checkOutput("model io_allow_in", 32'(io_allow_in), 32'(!m_valid || (ready && wb_allow_in)));
            checkOutput("model io_to_wb_valid", 32'(io_to_wb_valid), 32'(m_valid && ready));
            checkOutput("model back_pass_valid", 32'(io_to_id_back_pass_valid), 32'(pass));
            checkOutput("model back_pass_data_valid", 32'(io_to_id_back_pass_data_valid), 32'(pass && ready));
            if (m_valid) begin
                checkOutput("model program_count", io_to_wb_program_count, m_ins.program_count);
                checkOutput("model destination", 32'(io_to_wb_destination_register), 32'(m_ins.destination_register));
                checkOutput("model register_write", 32'(io_to_wb_register_write), 32'(m_ins.register_write));
                checkOutput("model result", io_to_wb_result, expResult(m_ins, rd, m_hi, m_lo));
            end
            if (pass) begin
                checkOutput("model back_pass_register", 32'(io_to_id_back_pass_register), 32'(m_ins.destination_register));
                checkOutput("model back_pass_data", io_to_id_back_pass_data, expResult(m_ins, rd, m_hi, m_lo));
            end
        end
    end

    // One cycle: inputs change just after the rising edge, checks follow at the falling edge.
    task automatic applyStimulus(input EXToIOData b, input logic [31:0] read_data, input logic wb);
        @(posedge clock);
        #1;
        bus         = b;
        rd          = read_data;
        wb_allow_in = wb;
        @(negedge clock);
    endtask

    function automatic EXToIOData mkIns(input logic [31:0] pc, input logic [4:0] dest, input logic rw);
        EXToIOData i;
        i                      = '0;
        i.valid                = 1'b1;
        i.program_count        = pc;
        i.destination_register = dest;
        i.register_write       = rw;
        return i;
    endfunction

    EXToIOData idle = '0;
    EXToIOData ins;
    EXToIOData ins2;
    EXToIOData divLive;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        checkOutput("reset wb_valid", 32'(io_to_wb_valid), 32'd0);
        checkOutput("reset allow_in", 32'(io_allow_in), 32'd1);
        checkOutput("reset back_pass_valid", 32'(io_to_id_back_pass_valid), 32'd0);

        ins = mkIns(32'h100, 5'd3, 1'b1);
        ins.alu_result = 32'h1234_5678;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("alu result", io_to_wb_result, 32'h1234_5678);
        checkOutput("alu pc", io_to_wb_program_count, 32'h100);

        ins = mkIns(32'h104, 5'd4, 1'b1);
        ins.result_is_from_memory = 1'b1;
        ins.is_load_byte = 1'b1;
        ins.memory_address_final = 2'd1;
        ins2 = ins;
        ins2.program_count = 32'h108;
        ins2.memory_io_unsigned = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(ins2, 32'h0000_80FF, 1'b1);
        checkOutput("lb signed", io_to_wb_result, 32'hFFFF_FF80);
        applyStimulus(idle, 32'h0000_80FF, 1'b1);
        checkOutput("lbu", io_to_wb_result, 32'h0000_0080);

        ins = mkIns(32'h10C, 5'd5, 1'b1);
        ins.result_is_from_memory = 1'b1;
        ins.is_load_half_word = 1'b1;
        ins.memory_address_final = 2'd2;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(idle, 32'h8001_0000, 1'b1);
        checkOutput("lh signed a2", io_to_wb_result, 32'hFFFF_8001);
        ins.memory_address_final = 2'd0;
        ins.memory_io_unsigned = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(idle, 32'h0000_F00F, 1'b1);
        checkOutput("lhu a0", io_to_wb_result, 32'h0000_F00F);
        ins = mkIns(32'h110, 5'd6, 1'b1);
        ins.result_is_from_memory = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(idle, 32'hCAFE_BABE, 1'b1);
        checkOutput("lw", io_to_wb_result, 32'hCAFE_BABE);

        ins = mkIns(32'h120, 5'd7, 1'b1);
        ins.result_is_from_memory = 1'b1;
        ins.source_register_data = 32'hAABB_CCDD;
        ins.memory_address_final = 2'd1;
        ins2 = ins;
        ins.is_load_left = 1'b1;
        ins2.is_load_right = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(ins2, 32'h1122_3344, 1'b1);
        checkOutput("lwl a1", io_to_wb_result, 32'h3344_CCDD);
        applyStimulus(idle, 32'h1122_3344, 1'b1);
        checkOutput("lwr a1", io_to_wb_result, 32'hAA11_2233);
        for (int a = 0; a < 4; a++) begin
            ins.memory_address_final = 2'(a);
            ins2.memory_address_final = 2'(a);
            applyStimulus(ins, 32'h1122_3344, 1'b1);
            applyStimulus(ins2, 32'h1122_3344, 1'b1);
        end
        applyStimulus(idle, 32'h1122_3344, 1'b1);

        // MULT, MFHI and MFLO issued back to back.
        ins = mkIns(32'h200, 5'd0, 1'b0);
        ins.multiply_valid = 1'b1;
        ins.high_low_write = 1'b1;
        ins.multiply_result = 64'h0000_0001_FFFF_FFFE;
        applyStimulus(ins, 32'h0, 1'b1);
        ins = mkIns(32'h204, 5'd8, 1'b1);
        ins.result_high = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        ins = mkIns(32'h208, 5'd9, 1'b1);
        ins.result_low = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        checkOutput("mfhi after mult", io_to_wb_result, 32'h0000_0001);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("mflo after mult", io_to_wb_result, 32'hFFFF_FFFE);

        ins = mkIns(32'h20C, 5'd0, 1'b0);
        ins.high_low_write = 1'b1;
        ins.result_high = 1'b1;
        ins.source_register_data = 32'hDEAD_BEEF;
        applyStimulus(ins, 32'h0, 1'b1);
        ins = mkIns(32'h210, 5'd10, 1'b1);
        ins.result_high = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("mfhi after mthi", io_to_wb_result, 32'hDEAD_BEEF);

        // DIV waits in IO until the divider reports its result.
        ins = mkIns(32'h300, 5'd0, 1'b0);
        ins.divide_valid = 1'b1;
        ins.high_low_write = 1'b1;
        ins.divide_result = 32'd7;
        ins.divide_remain = 32'd3;
        divLive = '0;
        divLive.divide_valid = 1'b1;
        divLive.divide_result = 32'd7;
        divLive.divide_remain = 32'd3;
        applyStimulus(ins, 32'h0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(divLive, 32'h0, 1'b1);
            checkOutput("div stall wb_valid", 32'(io_to_wb_valid), 32'd0);
            checkOutput("div stall allow_in", 32'(io_allow_in), 32'd0);
            checkOutput("div stall data_valid", 32'(io_to_id_back_pass_data_valid), 32'd0);
        end
        divLive.divide_result_valid = 1'b1;
        applyStimulus(divLive, 32'h0, 1'b1);
        checkOutput("div done wb_valid", 32'(io_to_wb_valid), 32'd1);
        checkOutput("div done allow_in", 32'(io_allow_in), 32'd1);
        ins = mkIns(32'h304, 5'd11, 1'b1);
        ins.result_low = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        ins = mkIns(32'h308, 5'd12, 1'b1);
        ins.result_high = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        checkOutput("mflo quotient", io_to_wb_result, 32'd7);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("mfhi remainder", io_to_wb_result, 32'd3);

        // WB backpressure on an ALU op, then on an MTLO with MFLO waiting in EX.
        ins = mkIns(32'h400, 5'd13, 1'b1);
        ins.alu_result = 32'hA5A5_5A5A;
        applyStimulus(ins, 32'h0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(idle, 32'h0, 1'b0);
            checkOutput("bp wb_valid", 32'(io_to_wb_valid), 32'd1);
            checkOutput("bp allow_in", 32'(io_allow_in), 32'd0);
            checkOutput("bp result", io_to_wb_result, 32'hA5A5_5A5A);
            checkOutput("bp pc", io_to_wb_program_count, 32'h400);
        end
        applyStimulus(idle, 32'h0, 1'b1);
        ins = mkIns(32'h404, 5'd0, 1'b0);
        ins.high_low_write = 1'b1;
        ins.result_low = 1'b1;
        ins.source_register_data = 32'h0000_0055;
        applyStimulus(ins, 32'h0, 1'b1);
        ins2 = mkIns(32'h408, 5'd14, 1'b1);
        ins2.result_low = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(ins2, 32'h0, 1'b0);
            checkOutput("bp mtlo pc", io_to_wb_program_count, 32'h404);
        end
        applyStimulus(ins2, 32'h0, 1'b1);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("mflo after stalled mtlo", io_to_wb_result, 32'h0000_0055);

        // Reset arrives while a DIV is stalled.
        ins = mkIns(32'h500, 5'd0, 1'b0);
        ins.divide_valid = 1'b1;
        ins.high_low_write = 1'b1;
        divLive.divide_result_valid = 1'b0;
        applyStimulus(ins, 32'h0, 1'b1);
        applyStimulus(divLive, 32'h0, 1'b1);
        applyStimulus(divLive, 32'h0, 1'b1);
        @(posedge clock);
        #1 reset = 1'b1;
        divLive.divide_result_valid = 1'b1;
        bus = divLive;
        @(posedge clock);
        #1 reset = 1'b0;
        bus = idle;
        @(negedge clock);
        checkOutput("post-reset wb_valid", 32'(io_to_wb_valid), 32'd0);
        checkOutput("post-reset allow_in", 32'(io_allow_in), 32'd1);
        ins = mkIns(32'h504, 5'd15, 1'b1);
        ins.result_high = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        ins = mkIns(32'h508, 5'd16, 1'b1);
        ins.result_low = 1'b1;
        applyStimulus(ins, 32'h0, 1'b1);
        checkOutput("post-reset mfhi", io_to_wb_result, 32'h0);
        applyStimulus(idle, 32'h0, 1'b1);
        checkOutput("post-reset mflo", io_to_wb_result, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
